// File: rtl/imem_read_arbiter.sv
// imem_read_arbiter: round-robin two-master AXI4-Lite read arbiter for the shared imem port,
// one transaction in flight, with the slave read data buffered before it goes to the master.
module imem_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
  input  logic                  i_m0_arvalid,
  output logic                  o_m0_arready,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  output logic                  o_m0_rvalid,
  input  logic                  i_m0_rready,
  input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
  input  logic                  i_m1_arvalid,
  output logic                  o_m1_arready,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_m1_rvalid,
  input  logic                  i_m1_rready,
  output logic [ADDR_WIDTH-1:0] o_s_araddr,
  output logic                  o_s_arvalid,
  input  logic                  i_s_arready,
  input  logic [DATA_WIDTH-1:0] i_s_rdata,
  input  logic                  i_s_rvalid,
  output logic                  o_s_rready,
  output logic                  o_grant,
  output logic                  o_busy
);
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
  state_t r_state, w_state;
  logic r_last_grant, w_last_grant, r_grant, w_grant;
  logic [ADDR_WIDTH-1:0] r_s_araddr, w_s_araddr;
  logic r_s_arvalid, w_s_arvalid, r_s_rready, w_s_rready;
  logic r_m0_arready, w_m0_arready, r_m1_arready, w_m1_arready;
  logic r_m0_rvalid, w_m0_rvalid, r_m1_rvalid, w_m1_rvalid;
  logic [DATA_WIDTH-1:0] r_m0_rdata, w_m0_rdata, r_m1_rdata, w_m1_rdata;
  logic w_pick;
  // On contention the master that did not win last time goes first.
  assign w_pick = (i_m0_arvalid & i_m1_arvalid) ? ~r_last_grant : i_m1_arvalid;
  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant      = r_grant;
    w_s_araddr   = r_s_araddr;
    w_s_arvalid  = r_s_arvalid;
    w_s_rready   = r_s_rready;
    w_m0_arready = 1'b0;
    w_m1_arready = 1'b0;
    w_m0_rvalid  = r_m0_rvalid;
    w_m1_rvalid  = r_m1_rvalid;
    w_m0_rdata   = r_m0_rdata;
    w_m1_rdata   = r_m1_rdata;
    case (r_state)
      IDLE: if (i_m0_arvalid | i_m1_arvalid) begin
        w_state      = AR;
        w_grant      = w_pick;
        w_s_araddr   = w_pick ? i_m1_araddr : i_m0_araddr;
        w_s_arvalid  = 1'b1;
        w_m0_arready = ~w_pick;
        w_m1_arready = w_pick;
      end
      AR: if (i_s_arready) begin
        w_state     = R;
        w_s_arvalid = 1'b0;
        w_s_rready  = 1'b1;
      end
      R: if (i_s_rvalid) begin
        w_state     = RESP;
        w_s_rready  = 1'b0;
        w_m0_rvalid = ~r_grant;
        w_m1_rvalid = r_grant;
        w_m0_rdata  = r_grant ? r_m0_rdata : i_s_rdata;
        w_m1_rdata  = r_grant ? i_s_rdata : r_m1_rdata;
      end
      RESP: if (r_grant ? i_m1_rready : i_m0_rready) begin
        w_state      = IDLE;
        w_m0_rvalid  = 1'b0;
        w_m1_rvalid  = 1'b0;
        w_last_grant = r_grant;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_s_araddr   <= '0;
      r_s_arvalid  <= 1'b0;
      r_s_rready   <= 1'b0;
      r_m0_arready <= 1'b0;
      r_m1_arready <= 1'b0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_grant      <= w_grant;
      r_s_araddr   <= w_s_araddr;
      r_s_arvalid  <= w_s_arvalid;
      r_s_rready   <= w_s_rready;
      r_m0_arready <= w_m0_arready;
      r_m1_arready <= w_m1_arready;
      r_m0_rvalid  <= w_m0_rvalid;
      r_m1_rvalid  <= w_m1_rvalid;
      r_m0_rdata   <= w_m0_rdata;
      r_m1_rdata   <= w_m1_rdata;
    end
  end
  assign o_m0_arready = r_m0_arready;
  assign o_m1_arready = r_m1_arready;
  assign o_m0_rvalid  = r_m0_rvalid;
  assign o_m1_rvalid  = r_m1_rvalid;
  assign o_m0_rdata   = r_m0_rdata;
  assign o_m1_rdata   = r_m1_rdata;
  assign o_s_araddr   = r_s_araddr;
  assign o_s_arvalid  = r_s_arvalid;
  assign o_s_rready   = r_s_rready;
  assign o_grant      = r_grant;
  assign o_busy       = (r_state != IDLE);
endmodule
